alu_result_stage: RTL and testbench

- Registered output stage directly downstream of the 32-bit ALU result mux.
- Captures the mux result, its 2-bit select, and adder carry/overflow, and generates zero/negative flags.
- Buffers up to two results in a 2-entry skid FIFO behind a valid/ready handshake, so ALU consumers can stall without loss.
- Keeps a sticky overflow flag and a 16-bit count of retired operations.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_flag_gen.sv | 23 ++
 rtl/alu_result_stage.sv | 120 ++++++++++++
 tb/tb_alu_result_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and entry-metadata definitions for the ALU result path.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_NEG   = 1;
    localparam int FLG_CARRY = 2;
    localparam int FLG_OVF   = 3;

    // Everything stored alongside a result except the result itself.
    typedef struct packed {
        logic [1:0] select;
        logic [3:0] flags;
    } meta_t;

    // Only the adder produces meaningful carry and overflow.
    function automatic logic is_arith(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Flag generator: {ovf, carry, neg, zero} from a mux result, combinational (0 cycles).
// No handshake; carry/ovf are masked for logical opcodes.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] result,
    input  logic [1:0]       select,
    input  logic             carry,
    input  logic             ovf,
    output logic [3:0]       flags
);

    always_comb begin
        flags            = '0;
        flags[FLG_ZERO]  = (result == '0);
        flags[FLG_NEG]   = result[WIDTH-1];
        flags[FLG_CARRY] = is_arith(select) & carry;
        flags[FLG_OVF]   = is_arith(select) & ovf;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage with 2-entry in-order skid buffer, sticky ovf, retired count.
// Latency 1 cycle from empty; in_ready depends only on registered level, never on out_ready.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [1:0]       in_select,
    input  logic             in_carry,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [1:0]       out_select,
    output logic [3:0]       out_flags,
    output logic             sticky_ovf,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [1:0]       level
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       level_q;
    logic [WIDTH-1:0] head_result;
    logic [WIDTH-1:0] tail_result;
    meta_t            head_meta;
    meta_t            tail_meta;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;

    logic             push;
    logic             pop;
    logic [3:0]       new_flags;
    meta_t            new_meta;

    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .result (in_result),
        .select (in_select),
        .carry  (in_carry),
        .ovf    (in_ovf),
        .flags  (new_flags)
    );

    assign new_meta  = '{select: in_select, flags: new_flags};
    assign in_ready  = (level_q != 2'd2);
    assign out_valid = (level_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head is entry 0 and feeds the outputs directly; tail only fills at level 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q     <= 2'd0;
            head_result <= '0;
            head_meta   <= '0;
            tail_result <= '0;
            tail_meta   <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    level_q <= level_q + 2'd1;
                    if (level_q == 2'd0) begin
                        head_result <= in_result;
                        head_meta   <= new_meta;
                    end else begin
                        tail_result <= in_result;
                        tail_meta   <= new_meta;
                    end
                end
                2'b01: begin
                    level_q <= level_q - 2'd1;
                    if (level_q == 2'd2) begin
                        head_result <= tail_result;
                        head_meta   <= tail_meta;
                    end
                end
                2'b11: begin
                    // Only reachable at level 1, so the new entry becomes the head.
                    head_result <= in_result;
                    head_meta   <= new_meta;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (pop && head_meta.flags[FLG_OVF]) begin
                sticky_q <= 1'b1;
            end else if (sticky_clr) begin
                sticky_q <= 1'b0;
            end
            if (pop) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign out_result  = head_result;
    assign out_select  = head_meta.select;
    assign out_flags   = head_meta.flags;
    assign sticky_ovf  = sticky_q;
    assign retired_cnt = cnt_q;
    assign level       = level_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scenario bench for alu_result_stage with a queue scoreboard and occupancy model.
`timescale 1ns/1ps
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [1:0]  in_select;
    logic        in_carry;
    logic        in_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [1:0]  out_select;
    logic [3:0]  out_flags;
    logic        sticky_ovf;
    logic        sticky_clr;
    logic [15:0] retired_cnt;
    logic [1:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] r;
        logic [1:0]  s;
        logic [3:0]  f;
    } exp_t;

    exp_t        sb[$];
    int          mlevel = 0;
    logic [15:0] mcnt   = 16'd0;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_select   (in_select),
        .in_carry    (in_carry),
        .in_ovf      (in_ovf),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_select  (out_select),
        .out_flags   (out_flags),
        .sticky_ovf  (sticky_ovf),
        .sticky_clr  (sticky_clr),
        .retired_cnt (retired_cnt),
        .level       (level)
    );

    function automatic logic [3:0] exp_flags(input logic [31:0] r, input logic [1:0] s,
                                             input logic c, input logic o);
        logic arith;
        arith = (s == 2'b00) || (s == 2'b01);
        return {arith & o, arith & c, r[31], (r == 32'd0)};
    endfunction

    // Model evaluated mid-cycle; inputs are stable until the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mlevel = 0;
            mcnt   = 16'd0;
            sb.delete();
        end else begin
            logic m_push, m_pop;
            exp_t e;
            n_checks += 4;
            if (in_ready !== (mlevel != 2)) begin
                n_fail++; $display("FAIL in_ready: got %b want %b", in_ready, (mlevel != 2));
            end
            if (out_valid !== (mlevel != 0)) begin
                n_fail++; $display("FAIL out_valid: got %b want %b", out_valid, (mlevel != 0));
            end
            if (level !== mlevel[1:0]) begin
                n_fail++; $display("FAIL level: got %0d want %0d", level, mlevel);
            end
            if (retired_cnt !== mcnt) begin
                n_fail++; $display("FAIL retired_cnt_model: got %0d want %0d", retired_cnt, mcnt);
            end
            m_pop  = (mlevel != 0) && out_ready;
            m_push = in_valid && (mlevel != 2);
            if (mlevel != 0) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL scoreboard_empty: head present with no expected entry");
                end else if ({out_result, out_select, out_flags} !== sb[0]) begin
                    n_fail++;
                    $display("FAIL head: got r=%h s=%0d f=%b want r=%h s=%0d f=%b",
                             out_result, out_select, out_flags, sb[0].r, sb[0].s, sb[0].f);
                end
            end
            if (m_pop) begin
                if (sb.size() > 0) void'(sb.pop_front());
                mcnt = mcnt + 16'd1;
            end
            if (m_push) begin
                e.r = in_result;
                e.s = in_select;
                e.f = exp_flags(in_result, in_select, in_carry, in_ovf);
                sb.push_back(e);
            end
            mlevel = mlevel + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [1:0] s,
                         input logic c, input logic o);
        in_valid  = v;
        in_result = r;
        in_select = s;
        in_carry  = c;
        in_ovf    = o;
    endtask

    task automatic test_reset();
        #1;
        n_checks += 3;
        if ({out_valid, in_ready, level} !== 4'b0100) begin
            n_fail++; $display("FAIL reset_ctrl: got v=%b r=%b lvl=%0d want 0 1 0", out_valid, in_ready, level);
        end
        if ({out_result, out_select, out_flags} !== 38'd0) begin
            n_fail++; $display("FAIL reset_data: got r=%h s=%0d f=%b want zeros", out_result, out_select, out_flags);
        end
        if ({sticky_ovf, retired_cnt} !== 17'd0) begin
            n_fail++; $display("FAIL reset_stat: got sticky=%b cnt=%0d want 0 0", sticky_ovf, retired_cnt);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 32'd0, 2'b00, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if ({out_valid, out_result, out_flags} !== {1'b1, 32'd0, 4'b0101}) begin
            n_fail++; $display("FAIL single_out: got v=%b r=%h f=%b want 1 0 0101", out_valid, out_result, out_flags);
        end
        step();
        n_checks++;
        if (retired_cnt !== 16'd1 || level !== 2'd0) begin
            n_fail++; $display("FAIL single_retire: got cnt=%0d lvl=%0d want 1 0", retired_cnt, level);
        end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_0000, 2'b01, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h0000_00FF, 2'b10, 1'b1, 1'b0);
        step();
        n_checks++;
        if (level !== 2'd2 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_full: got lvl=%0d rdy=%b want 2 0", level, in_ready);
        end
        drive(1'b1, 32'h1234_5678, 2'b00, 1'b1, 1'b1);
        step();
        step();
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (level !== 2'd2 || out_result !== 32'h8000_0000 || out_flags !== 4'b1010) begin
            n_fail++; $display("FAIL fill_hold: got lvl=%0d r=%h f=%b want 2 80000000 1010", level, out_result, out_flags);
        end
    endtask

    task automatic test_drain();
        n_checks++;
        if (sticky_ovf !== 1'b0) begin
            n_fail++; $display("FAIL drain_sticky_pre: got %b want 0", sticky_ovf);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (sticky_ovf !== 1'b1 || out_result !== 32'hFF || out_flags !== 4'b0000) begin
            n_fail++; $display("FAIL drain_first: got sticky=%b r=%h f=%b want 1 ff 0000", sticky_ovf, out_result, out_flags);
        end
        step();
        out_ready = 1'b0;
        n_checks++;
        if (level !== 2'd0 || retired_cnt !== 16'd3) begin
            n_fail++; $display("FAIL drain_done: got lvl=%0d cnt=%0d want 0 3", level, retired_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        base = 32'hA000_0000;
        out_ready = 1'b0;
        drive(1'b1, base, 2'b00, 1'b0, 1'b0);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, base + 32'(i) + 32'd1, 2'(i), 1'($urandom), 1'($urandom));
            step();
        end
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (level !== 2'd1 || retired_cnt !== 16'd203 || out_result !== base + 32'd200) begin
            n_fail++; $display("FAIL b2b_end: got lvl=%0d cnt=%0d r=%h want 1 203 %h", level, retired_cnt, out_result, base + 32'd200);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_sticky();
        out_ready = 1'b0;
        drive(1'b1, 32'h7FFF_FFFF, 2'b00, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        out_ready  = 1'b1;
        sticky_clr = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (sticky_ovf !== 1'b1) begin
            n_fail++; $display("FAIL sticky_set_wins: got %b want 1", sticky_ovf);
        end
        step();
        sticky_clr = 1'b0;
        n_checks++;
        if (sticky_ovf !== 1'b0) begin
            n_fail++; $display("FAIL sticky_clear: got %b want 0", sticky_ovf);
        end
        drive(1'b1, 32'h1, 2'b00, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (sticky_ovf !== 1'b0 || retired_cnt !== 16'd206) begin
            n_fail++; $display("FAIL sticky_no_ovf: got sticky=%b cnt=%0d want 0 206", sticky_ovf, retired_cnt);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'hDEAD_0001, 2'b11, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'hDEAD_0002, 2'b01, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || level !== 2'd0 || in_ready !== 1'b1 || retired_cnt !== 16'd0) begin
            n_fail++; $display("FAIL async_reset: got v=%b lvl=%0d rdy=%b cnt=%0d want 0 0 1 0", out_valid, level, in_ready, retired_cnt);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        drive(1'b1, 32'h0BAD_F00D, 2'b01, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || level !== 2'd1 || out_result !== 32'h0BAD_F00D || out_flags !== 4'b0100) begin
            n_fail++; $display("FAIL post_reset_push: got v=%b lvl=%0d r=%h f=%b want 1 1 0badf00d 0100", out_valid, level, out_result, out_flags);
        end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        out_ready = 1'b0;
        drive(1'b1, 32'd0, 2'b10, 1'b0, 1'b0);
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 65535; i++) begin
            drive(1'b1, 32'(i), 2'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (retired_cnt !== 16'hFFFF || level !== 2'd1) begin
            n_fail++; $display("FAIL wrap_max: got cnt=%0d lvl=%0d want 65535 1", retired_cnt, level);
        end
        step();
        out_ready = 1'b0;
        n_checks++;
        if (retired_cnt !== 16'd0 || level !== 2'd0) begin
            n_fail++; $display("FAIL wrap_zero: got cnt=%0d lvl=%0d want 0 0", retired_cnt, level);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_back_to_back();
        test_sticky();
        test_async_reset();
        test_wrap();
        step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
